reg_bank_arbiter: RTL and testbench

- Owns the device register bank (NREGS x 8 bit) in the system clock domain.
- Arbitrates it between two requesters: port 0 is the SPI slave bridge, already synchronised to clk; port 1 is the PWM sequencer.
- Each access uses a valid/ready request and a one-cycle response.
- Round-robin fairness; exactly one access in flight at a time.
- All register contents are exported flat so the PWM datapath can read them continuously.

---
 rtl/reg_bank_arbiter_pkg.sv | 8 +
 rtl/reg_bank_arbiter_rr_arb2.sv | 12 +
 rtl/reg_bank_arbiter.sv | 109 ++++++++++
 tb/tb_reg_bank_arbiter.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/reg_bank_arbiter_pkg.sv
// regbank_pkg: FSM encoding, port indices and reset defaults shared by reg_bank_arbiter.
package regbank_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_t;
    localparam int PORT_SPI = 0;
    localparam int PORT_PWM = 1;
    localparam logic [7:0] DEV_ID = 8'h96;
    localparam logic [31:0] RST_VALS_DEF = {8'h03, 8'h02, 8'h01, DEV_ID};
endpackage

// File: rtl/reg_bank_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin picker; ptr_i selects the preferred port when both request.
module rr_arb2 (
    input  logic [1:0] valid_i,
    input  logic       ptr_i,
    output logic [1:0] grant_o,
    output logic       grant_vld_o
);
    always_comb begin
        grant_o = (valid_i == 2'b11) ? (ptr_i ? 2'b10 : 2'b01) : valid_i;
        grant_vld_o = |valid_i;
    end
endmodule

// File: rtl/reg_bank_arbiter.sv
// reg_bank_arbiter: NREGS x 8 register bank shared by the SPI bridge (port 0) and PWM sequencer (port 1).
// Define REGBANK_ID_LOCK_EN to make register 0 (device ID) read-only.
module reg_bank_arbiter
    import regbank_pkg::*;
#(
    parameter int NREGS = 4,
    parameter int ADDR_W = 7,
    parameter logic [8*NREGS-1:0] RST_VALS = RST_VALS_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          req_valid,
    input  logic [1:0]          req_write,
    input  logic [2*ADDR_W-1:0] req_addr,
    input  logic [15:0]         req_wdata,
    output logic [1:0]          req_ready,
    output logic [1:0]          rsp_valid,
    output logic [7:0]          rsp_rdata,
    output logic                rsp_err,
    output logic [8*NREGS-1:0]  regs_flat
);
    localparam int IDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;

    state_t            state_q, state_d;
    logic              rr_ptr_q, rr_ptr_d;
    logic              grant_q, grant_d;
    logic [7:0]        regs_q [NREGS];
    logic [7:0]        regs_d [NREGS];
    logic [7:0]        rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic [1:0]        pick;
    logic              pick_vld;
    logic [ADDR_W-1:0] addr;
    logic [IDX_W-1:0]  idx;
    logic [7:0]        wdata;
    logic              wr, in_range, locked;

    rr_arb2 u_arb (
        .valid_i    (req_valid),
        .ptr_i      (rr_ptr_q),
        .grant_o    (pick),
        .grant_vld_o(pick_vld)
    );

    assign addr     = grant_q ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
    assign wdata    = grant_q ? req_wdata[15:8] : req_wdata[7:0];
    assign wr       = req_write[grant_q];
    assign idx      = addr[IDX_W-1:0];
    assign in_range = addr < ADDR_W'(NREGS);
`ifdef REGBANK_ID_LOCK_EN
    assign locked = wr && idx == '0;
`else
    assign locked = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        regs_d      = regs_q;
        case (state_q)
            ST_IDLE: if (pick_vld) begin
                grant_d = (pick == 2'b10);
                state_d = ST_ACCESS;
            end
            ST_ACCESS: if (req_valid[grant_q]) begin
                state_d     = ST_RESP;
                rr_ptr_d    = ~grant_q;
                rsp_err_d   = !in_range || locked;
                rsp_rdata_d = !in_range ? 8'h00 : (wr && !locked) ? wdata : regs_q[idx];
                if (in_range && wr && !locked) regs_d[idx] = wdata;
            end else begin
                // Requester withdrew: drop the access without touching the pointer.
                state_d = ST_IDLE;
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= 1'b0;
            grant_q     <= 1'b0;
            rsp_rdata_q <= 8'h00;
            rsp_err_q   <= 1'b0;
            for (int i = 0; i < NREGS; i++) regs_q[i] <= RST_VALS[8*i +: 8];
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            regs_q      <= regs_d;
        end
    end

    assign req_ready = (state_q == ST_ACCESS) ? {grant_q == 1'(PORT_PWM), grant_q == 1'(PORT_SPI)} : 2'b00;
    assign rsp_valid = (state_q == ST_RESP) ? {grant_q == 1'(PORT_PWM), grant_q == 1'(PORT_SPI)} : 2'b00;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    for (genvar i = 0; i < NREGS; i++) begin : g_flat
        assign regs_flat[8*i +: 8] = regs_q[i];
    end
endmodule

// File: tb/tb_reg_bank_arbiter.sv
// tb_reg_bank_arbiter: directed plus randomized accesses checked against a register-array model.
module tb_reg_bank_arbiter;
`ifdef REGBANK_ID_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid = '0, req_write = '0;
    logic [13:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic [1:0]  req_ready, rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;
    logic [31:0] regs_flat;

    int checks = 0, passes = 0, fails = 0;
    logic [7:0]  model [4];
    logic [31:0] rst_vals = 32'h03020196;
    int          pref = 0;
    logic [7:0]  exp_d;
    logic        exp_e;

    always #5 clk = ~clk;

    reg_bank_arbiter dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .regs_flat(regs_flat)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] flat();
        logic [31:0] f;
        for (int i = 0; i < 4; i++) f[8*i +: 8] = model[i];
        return f;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) model[i] = rst_vals[8*i +: 8];
        pref = 0;
    endtask

    task automatic set_req(input int p, input logic w, input logic [6:0] a, input logic [7:0] d);
        req_write[p]        = w;
        req_addr[7*p +: 7]  = a;
        req_wdata[8*p +: 8] = d;
        req_valid[p]        = 1'b1;
    endtask

    // Called at a negedge in IDLE with requests already driven.
    task automatic txn();
        int          w, a;
        logic        wr;
        logic [7:0]  d;
        logic [31:0] pre;
        w   = (req_valid == 2'b11) ? pref : (req_valid == 2'b10 ? 1 : 0);
        a   = int'(req_addr[7*w +: 7]);
        wr  = req_write[w];
        d   = req_wdata[8*w +: 8];
        pre = flat();
        @(negedge clk);
        check("ready", 32'(req_ready), 32'(1 << w));
        check("rspv_acc", 32'(rsp_valid), 0);
        check("flat_acc", regs_flat, pre);
        if (a < 4) begin
            if (wr && !(LOCK && a == 0)) begin
                model[a] = d; exp_d = d; exp_e = 1'b0;
            end else if (wr) begin
                exp_d = model[0]; exp_e = 1'b1;
            end else begin
                exp_d = model[a]; exp_e = 1'b0;
            end
        end else begin
            exp_d = 8'h00; exp_e = 1'b1;
        end
        pref = 1 - w;
        @(negedge clk);
        check("rspv", 32'(rsp_valid), 32'(1 << w));
        check("ready_rsp", 32'(req_ready), 0);
        check("rdata", 32'(rsp_rdata), 32'(exp_d));
        check("err", 32'(rsp_err), 32'(exp_e));
        check("flat", regs_flat, flat());
        req_valid[w] = 1'b0;
        @(negedge clk);
        check("rspv_idle", 32'(rsp_valid), 0);
        check("hold", 32'(rsp_rdata), 32'(exp_d));
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(req_ready), 0);
        check("rst_rspv", 32'(rsp_valid), 0);
        check("rst_rdata", 32'(rsp_rdata), 0);
        check("rst_err", 32'(rsp_err), 0);
        check("rst_flat", regs_flat, 32'h03020196);
        rst_n = 1'b1;
        @(negedge clk);

        set_req(0, 1'b0, 7'd0, 8'h00); txn();
        check("id_read", 32'(rsp_rdata), 32'h96);
        set_req(1, 1'b1, 7'd2, 8'h5A); txn();
        check("flat_b2", 32'(regs_flat[23:16]), 32'h5A);
        set_req(1, 1'b0, 7'd2, 8'h00); txn();
        set_req(0, 1'b0, 7'h05, 8'h00); txn();
        set_req(0, 1'b1, 7'h05, 8'hC3); txn();
        set_req(1, 1'b1, 7'd0, 8'h00); txn();
        check("id_lock", 32'(regs_flat[7:0]), LOCK ? 32'h96 : 32'h00);

        // Port 0 withdraws during ACCESS; pointer must still favour port 0.
        set_req(0, 1'b1, 7'd1, 8'h77);
        @(negedge clk);
        check("abort_ready", 32'(req_ready), 1);
        req_valid = 2'b00;
        @(negedge clk);
        check("abort_rspv", 32'(rsp_valid), 0);
        check("abort_flat", regs_flat, flat());
        set_req(0, 1'b0, 7'd1, 8'h00); set_req(1, 1'b0, 7'd3, 8'h00); txn();
        req_valid = 2'b00;
        @(negedge clk);

        // Reset during the response of a write.
        set_req(0, 1'b1, 7'd1, 8'hFF);
        @(negedge clk);
        @(negedge clk);
        check("mid_rspv", 32'(rsp_valid), 1);
        rst_n = 1'b0;
        req_valid = 2'b00;
        @(negedge clk);
        check("mid_ready", 32'(req_ready), 0);
        check("mid_rspv0", 32'(rsp_valid), 0);
        check("mid_rdata", 32'(rsp_rdata), 0);
        check("mid_err", 32'(rsp_err), 0);
        check("mid_flat", regs_flat, 32'h03020196);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);

        // Both ports held: grants must alternate 0,1,0,1.
        for (int k = 0; k < 4; k++) begin
            if (!req_valid[0]) set_req(0, 1'b0, 7'd1, 8'h00);
            if (!req_valid[1]) set_req(1, 1'b0, 7'd3, 8'h00);
            check("fair_ptr", 32'(pref), 32'(k % 2));
            txn();
        end
        req_valid = 2'b00;

        for (int k = 0; k < 60; k++) begin
            for (int p = 0; p < 2; p++)
                if (!req_valid[p] && $urandom_range(0, 2) != 0)
                    set_req(p, 1'($urandom),
                            ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'($urandom_range(0, 5)),
                            8'($urandom));
            if (req_valid == 2'b00) set_req(int'($urandom_range(0, 1)), 1'b1, 7'($urandom_range(0, 3)), 8'($urandom));
            txn();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
